// File: rtl/cnn_dot_mac_seq_if.sv
// Block-level bus of the dot-product sequencer: ap_* handshake, job arguments,
// result, and the two single-port operand memory read ports.
interface cnn_dot_mac_seq_if #(
   parameter int A_W    = 14,
   parameter int B_W    = 8,
   parameter int ACC_W  = 32,
   parameter int ADDR_W = 10
);
   logic              ap_start;
   logic              ap_done;
   logic              ap_idle;
   logic              ap_ready;
   logic [ADDR_W:0]   len;
   logic [ADDR_W-1:0] base_a;
   logic [ADDR_W-1:0] base_b;
   logic [ACC_W-1:0]  bias;
   logic [ACC_W-1:0]  ap_return;
   logic [ADDR_W-1:0] a_address0;
   logic              a_ce0;
   logic [A_W-1:0]    a_q0;
   logic [ADDR_W-1:0] b_address0;
   logic              b_ce0;
   logic [B_W-1:0]    b_q0;

   modport slave (
      input  ap_start, len, base_a, base_b, bias, a_q0, b_q0,
      output ap_done, ap_idle, ap_ready, ap_return,
             a_address0, a_ce0, b_address0, b_ce0
   );

   modport master (
      output ap_start, len, base_a, base_b, bias, a_q0, b_q0,
      input  ap_done, ap_idle, ap_ready, ap_return,
             a_address0, a_ce0, b_address0, b_ce0
   );
endinterface

// File: rtl/cnn_dot_mac_seq.sv
// Dot-product sequencer: one shared signed multiplier streams operand pairs from two
// 1-cycle-latency memories through a registered product into a bias-seeded accumulator.
module cnn_dot_mac_seq #(
   parameter int A_W    = 14,
   parameter int B_W    = 8,
   parameter int P_W    = A_W + B_W,
   parameter int ACC_W  = 32,
   parameter int ADDR_W = 10
) (
   input  logic             ap_clk,
   input  logic             ap_rst_n,
   cnn_dot_mac_seq_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);

   state_t                  state_q, state_d;
   logic [ADDR_W:0]         len_q;
   logic [ADDR_W:0]         idx_q;
   logic [ADDR_W-1:0]       base_a_q, base_b_q;
   logic signed [P_W-1:0]   prod_q;
   logic signed [ACC_W-1:0] acc_q;
   logic [ACC_W-1:0]        ret_q;
   logic                    q_vld_q, prod_vld_q;
   logic                    accept, issue, last_issue;

   assign last_issue = (idx_q == len_q - ONE);

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) state_q <= IDLE;
      else           state_q <= state_d;
   end

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      accept      = 1'b0;
      issue       = 1'b0;
      bus.ap_idle = 1'b0;
      bus.ap_done = 1'b0;
      case (state_q)
         IDLE: begin
            bus.ap_idle = 1'b1;
            if (bus.ap_start) begin
               accept  = 1'b1;
               state_d = (bus.len == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            issue = 1'b1;
            if (last_issue) state_d = DRAIN;
         end
         DRAIN: begin
            if (idx_q[0]) state_d = DONE;
         end
         DONE: begin
            bus.ap_done = 1'b1;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.ap_ready   = bus.ap_done;
   assign bus.a_ce0      = issue;
   assign bus.b_ce0      = issue;
   assign bus.a_address0 = issue ? base_a_q + idx_q[ADDR_W-1:0] : '0;
   assign bus.b_address0 = issue ? base_b_q + idx_q[ADDR_W-1:0] : '0;
   // The final sum is visible in DONE itself and then held until the next DONE.
   assign bus.ap_return  = (state_q == DONE) ? acc_q : ret_q;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         len_q      <= '0;
         idx_q      <= '0;
         base_a_q   <= '0;
         base_b_q   <= '0;
         prod_q     <= '0;
         acc_q      <= '0;
         ret_q      <= '0;
         q_vld_q    <= 1'b0;
         prod_vld_q <= 1'b0;
      end else begin
         q_vld_q    <= issue;
         prod_vld_q <= q_vld_q;
         if (q_vld_q) prod_q <= $signed(bus.a_q0) * $signed(bus.b_q0);

         if (accept) begin
            len_q    <= bus.len;
            base_a_q <= bus.base_a;
            base_b_q <= bus.base_b;
            acc_q    <= bus.bias;
         end else if (prod_vld_q) begin
            acc_q <= acc_q + ACC_W'(prod_q);
         end

         // idx walks the issue index in RUN, then counts the two DRAIN cycles.
         if (accept)                  idx_q <= '0;
         else if (state_q == RUN)     idx_q <= last_issue ? '0 : idx_q + ONE;
         else if (state_q == DRAIN)   idx_q <= idx_q + ONE;

         if (state_q == DONE) ret_q <= acc_q;
      end
   end
endmodule

// File: tb/tb_cnn_dot_mac_seq.sv
// Directed self-checking bench for cnn_dot_mac_seq: hand-computed jobs, signed extremes,
// address and accumulator wrap, back-to-back starts and mid-job reset.
module tb_cnn_dot_mac_seq;
   logic clk = 1'b0;
   logic rst_n;
   int   checks   = 0;
   int   failures = 0;

   logic [13:0] amem [1024];
   logic [7:0]  bmem [1024];

   cnn_dot_mac_seq_if                 bus ();
   cnn_dot_mac_seq_if #(.ACC_W(22))   bus22 ();

   cnn_dot_mac_seq u_dut (.ap_clk(clk), .ap_rst_n(rst_n), .bus(bus));
   cnn_dot_mac_seq #(.ACC_W(22)) u_dut22 (.ap_clk(clk), .ap_rst_n(rst_n), .bus(bus22));

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.a_ce0)   bus.a_q0   <= amem[bus.a_address0];
      if (bus.b_ce0)   bus.b_q0   <= bmem[bus.b_address0];
      if (bus22.a_ce0) bus22.a_q0 <= amem[bus22.a_address0];
      if (bus22.b_ce0) bus22.b_q0 <= bmem[bus22.b_address0];
   end

   task automatic check(input string tag, input logic signed [63:0] obs,
                        input logic signed [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Runs one job on the 32-bit instance; cycle 0 is the start cycle.
   task automatic run_job(input string tag, input int n, input int ba, input int bb,
                          input int bias_v, input int exp_ret);
      int cyc = 0, done_cyc = -1, ce_cnt = 0, first_ce = -1, addr_err = 0;
      @(negedge clk);
      bus.ap_start = 1'b1;
      bus.len      = 11'(n);
      bus.base_a   = 10'(ba);
      bus.base_b   = 10'(bb);
      bus.bias     = 32'(bias_v);
      @(posedge clk); #1;
      bus.ap_start = 1'b0;
      bus.len      = 11'(n + 3);
      bus.base_a   = 10'(ba + 5);
      bus.base_b   = 10'(bb + 7);
      bus.bias     = 32'(bias_v + 1);
      cyc = 1;
      while (done_cyc < 0 && cyc < n + 12) begin
         if (bus.a_ce0) begin
            if (first_ce < 0) first_ce = cyc;
            if (bus.a_address0 !== 10'(ba + ce_cnt) || bus.b_address0 !== 10'(bb + ce_cnt)
                || bus.b_ce0 !== 1'b1)
               addr_err++;
            ce_cnt++;
         end
         if (bus.ap_done === 1'b1) begin
            done_cyc = cyc;
            check({tag, " ready"}, bus.ap_ready, 1);
            check({tag, " return"}, $signed(bus.ap_return), exp_ret);
         end else begin
            @(posedge clk); #1;
            cyc++;
         end
      end
      check({tag, " latency"}, done_cyc, (n == 0) ? 1 : n + 3);
      check({tag, " ce_count"}, ce_cnt, n);
      if (n > 0) check({tag, " first_ce"}, first_ce, 1);
      check({tag, " addr"}, addr_err, 0);
      @(posedge clk); #1;
      check({tag, " idle_after"}, bus.ap_idle, 1);
      check({tag, " done_low"}, bus.ap_done, 0);
      check({tag, " return_hold"}, $signed(bus.ap_return), exp_ret);
   endtask

   initial begin
      longint full_sum;
      int     done_mask, cnt22, done22;

      for (int i = 0; i < 1024; i++) begin
         amem[i] = 14'((i % 7) - 3);
         bmem[i] = 8'((i % 5) - 2);
      end
      amem[16] = 14'd1; amem[17] = 14'd2; amem[18] = 14'd3;
      bmem[32] = 8'd4;  bmem[33] = 8'd5;  bmem[34] = 8'd6;
      for (int i = 0; i < 4; i++) begin
         amem[100 + i] = 14'h2000;
         bmem[200 + i] = 8'h80;
         bmem[300 + i] = 8'd127;
      end
      amem[1023] = 14'd7; amem[0] = -14'sd3;
      bmem[500]  = 8'd2;  bmem[501] = 8'd9;
      amem[600]  = 14'd1; bmem[600] = 8'd1;

      rst_n = 1'b0;
      bus.ap_start = 1'b0; bus.len = '0; bus.base_a = '0; bus.base_b = '0; bus.bias = '0;
      bus22.ap_start = 1'b0; bus22.len = '0; bus22.base_a = '0; bus22.base_b = '0;
      bus22.bias = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst idle", bus.ap_idle, 1);
      check("rst done", bus.ap_done, 0);
      check("rst ready", bus.ap_ready, 0);
      check("rst ce", {bus.a_ce0, bus.b_ce0}, 0);
      check("rst addr", {bus.a_address0, bus.b_address0}, 0);
      check("rst return", bus.ap_return, 0);
      @(negedge clk);
      rst_n = 1'b1;

      run_job("basic", 3, 16, 32, 10, 42);
      run_job("len0", 0, 0, 0, -5, -5);
      run_job("neg_neg", 4, 100, 200, 0, 4194304);
      run_job("neg_pos", 4, 100, 300, 0, -4161536);
      run_job("addr_wrap", 2, 1023, 500, 0, -13);

      full_sum = 1;
      for (int i = 0; i < 1024; i++)
         full_sum += longint'($signed(amem[i])) * longint'($signed(bmem[(512 + i) % 1024]));
      run_job("full_mem", 1024, 0, 512, 1, int'(32'(full_sum)));

      // Accumulator wrap on the 22-bit instance.
      @(negedge clk);
      bus22.ap_start = 1'b1; bus22.len = 11'd1; bus22.base_a = 10'd600;
      bus22.base_b = 10'd600; bus22.bias = 22'd2097151;
      @(posedge clk); #1;
      bus22.ap_start = 1'b0;
      cnt22 = 1; done22 = -1;
      while (done22 < 0 && cnt22 < 12) begin
         if (bus22.ap_done === 1'b1) begin
            done22 = cnt22;
            check("acc_wrap return", $signed(bus22.ap_return), -2097152);
         end else begin
            @(posedge clk); #1;
            cnt22++;
         end
      end
      check("acc_wrap latency", done22, 4);

      // ap_start held high: done pulses at cycles 4, 9, 14 only.
      @(posedge clk); #1;
      @(negedge clk);
      bus.ap_start = 1'b1; bus.len = 11'd1; bus.base_a = 10'd0; bus.base_b = 10'd16;
      bus.bias = 32'd0;
      done_mask = 0;
      for (int k = 1; k <= 16; k++) begin
         @(posedge clk); #1;
         if (bus.ap_done === 1'b1) done_mask |= (1 << k);
         if (k == 14) bus.ap_start = 1'b0;
         if (k == 5) check("hold idle_c5", bus.ap_idle, 1);
      end
      check("hold done_mask", done_mask, (1 << 4) | (1 << 9) | (1 << 14));
      check("hold return", $signed(bus.ap_return), 3);

      // Reset pulse in the middle of a len=8 job.
      @(negedge clk);
      bus.ap_start = 1'b1; bus.len = 11'd8; bus.base_a = 10'd16; bus.base_b = 10'd32;
      bus.bias = 32'd0;
      @(posedge clk); #1;
      bus.ap_start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("mid_rst was_running", bus.a_ce0, 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst idle", bus.ap_idle, 1);
      check("mid_rst ce", {bus.a_ce0, bus.b_ce0}, 0);
      check("mid_rst addr", bus.a_address0, 0);
      check("mid_rst return", bus.ap_return, 0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      done_mask = 0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         if (bus.ap_done === 1'b1) done_mask++;
      end
      check("mid_rst no_done", done_mask, 0);
      run_job("after_rst", 3, 16, 32, 10, 42);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
